y86_dmem: RTL and testbench
===========================

# y86_dmem

Byte-addressed data memory for the Y86-64 pipeline, sitting directly downstream of the memory stage. It consumes the processor's store strobe, address and store data (M_valA) and returns the 64-bit load value (m_valM) and the data-memory error flag in the same cycle. After reset it clears its storage with a self-timed sweep. It also keeps sticky error and access statistics for the testbench and debug.

## Interface
- MEM_BYTES, 1024: storage size in bytes; power of two, multiple of 8, at least 16.
- CNT_W, 32: width of the load and store counters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- write_i  in  1  store strobe from the memory stage.
- read_i  in  1  load strobe from the memory stage (mrmovq/popq/ret).
- addr_i  in  64  byte address of the access.
- data_i  in  64  store data, little-endian.
- data_o  out  64  load data (m_valM), combinational.
- mem_error_o  out  1  access error this cycle (d_mem_error), combinational.
- ready_o  out  1  clear sweep finished; memory usable.
- err_sticky_o  out  1  set by any error; cleared only by reset.
- err_addr_o  out  64  address of the first error since reset.
- load_cnt_o  out  CNT_W  count of completed loads.
- store_cnt_o  out  CNT_W  count of completed stores.

## Operation
- Storage is MEM_BYTES x 8-bit. A 64-bit access covers bytes addr_i..addr_i+7, little-endian: byte addr_i maps to data bits [7:0]. Any alignment is allowed.
- Range error is `bad = (addr_i > MEM_BYTES-8)`, evaluated on the full 64-bit unsigned address. There is no wrap-around, so 0xFFFF_FFFF_FFFF_FFF9 is an error.
- mem_error_o = ready_o & (read_i | write_i) & bad. It is 0 when neither strobe is active.
- data_o is the stored 8 bytes when ready_o & read_i & ~bad, and 0 otherwise.
- A store commits at the rising edge when ready_o & write_i & ~bad. A store with bad=1 leaves memory unchanged.
- State machine, two states:
  - CLEAR (entered on reset): a byte-index counter clear_idx starts at 0. Each cycle it zeroes bytes clear_idx..clear_idx+7 and then adds 8. When the word at MEM_BYTES-8 has been cleared, the machine moves to READY.
  - READY: normal operation. It stays in READY until the next reset.
- During CLEAR, ready_o=0. Strobes are ignored: no write, no error, data_o=0, and no counter change.
- Both write_i and read_i high in one cycle is treated as a store:
  - the store commits;
  - data_o shows the pre-store contents;
  - load_cnt_o does not increment;
  - store_cnt_o increments if bad=0.
- Counters:
  - load_cnt_o increments on every READY cycle with read_i & ~write_i & ~bad.
  - store_cnt_o increments on every READY cycle with write_i & ~bad.
  - Both wrap modulo 2^CNT_W.
- Sticky error: on the first cycle with mem_error_o=1 and err_sticky_o=0, err_addr_o latches addr_i and err_sticky_o sets. Later errors do not change err_addr_o.

## Timing
- Reset values (rst=0): ready_o=0, err_sticky_o=0, err_addr_o=0, load_cnt_o=0, store_cnt_o=0. data_o=0 and mem_error_o=0 because ready_o=0. State=CLEAR, clear_idx=0.
- Reset asserted mid-sweep or mid-operation immediately forces the reset values and restarts the sweep from index 0.
- The sweep takes exactly MEM_BYTES/8 rising edges after rst goes high. ready_o rises after edge MEM_BYTES/8; for the default size that is edge 128.
- Load latency is 0 cycles: data_o and mem_error_o settle combinationally from addr_i and the strobes in the same cycle.
- A store becomes visible to a read in the cycle after its committing edge. A read in the same cycle as the store sees the old data.
- Counter and sticky-flag updates are visible one cycle after the qualifying access.

## Test plan
- **Reset sweep:** preload garbage by hierarchical force, then pulse rst low and release. Check ready_o=0 through edge 127 and ready_o=1 after edge 128. Reading 0x3F8 then returns 0.
- **Aligned store/load:** store 0x0123456789ABCDEF at 0x100. Next cycle, a read at 0x100 returns 0x0123456789ABCDEF; a read at 0x101 returns 0x000123456789ABCD. store_cnt_o=1 and load_cnt_o=2.
- **Boundary:** a store at 0x3F8 succeeds with mem_error_o=0. A read at 0x3F9 gives mem_error_o=1 and data_o=0, with err_addr_o=0x3F9 and err_sticky_o=1 the next cycle. A later error at 0xFFFF_FFFF_FFFF_FFF9 leaves err_addr_o at 0x3F9.
- **Simultaneous strobes:** with 0x11 stored at 0x40, drive write_i=read_i=1 at 0x40 with data 0x22. data_o=0x11 that cycle and reads 0x22 the next cycle. load_cnt_o is unchanged and store_cnt_o increases by 1.
- **Access during CLEAR:** on edge 10 after reset, store 0xAA at 0x0. mem_error_o=0, and after ready_o rises a read at 0x0 returns 0. Both counters stay 0.
- **Counter wrap:** with CNT_W=4, perform 17 valid loads and check load_cnt_o=1.

Source files
------------

// File: rtl/y86_dmem.sv
// rtl/y86_dmem.sv - Y86-64 byte-addressed data memory with post-reset clear sweep and access statistics
// Combinational 64-bit little-endian loads, edge-committed stores, sticky first-error capture.
module y86_dmem #(
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [63:0]      addr_i,
  input  logic [63:0]      data_i,
  output logic [63:0]      data_o,
  output logic             mem_error_o,
  output logic             ready_o,
  output logic             err_sticky_o,
  output logic [63:0]      err_addr_o,
  output logic [CNT_W-1:0] load_cnt_o,
  output logic [CNT_W-1:0] store_cnt_o
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_WORD = 64'(MEM_BYTES - 8);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clear_idx_q, clear_idx_d;
  logic [7:0]    mem [MEM_BYTES];

  logic          bad;
  logic          wr_en;
  logic          ld_en;
  logic          err;
  logic [AW-1:0] base;
  logic [63:0]   rd_word;

  // Compare the full address so high bits can never alias back into range.
  assign bad     = addr_i > LAST_WORD;
  assign base    = addr_i[AW-1:0];
  assign ready_o = (state_q == S_READY);

  // A simultaneous read+write is a store; it never counts as a load.
  assign wr_en       = ready_o & write_i & ~bad;
  assign ld_en       = ready_o & read_i & ~write_i & ~bad;
  assign err         = ready_o & (read_i | write_i) & bad;
  assign mem_error_o = err;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++) begin
      rd_word[8*k +: 8] = mem[base + AW'(k)];
    end
  end

  assign data_o = (ready_o & read_i & ~bad) ? rd_word : 64'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    case (state_q)
      S_CLEAR: begin
        clear_idx_d = clear_idx_q + AW'(8);
        if (clear_idx_q == AW'(MEM_BYTES - 8)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d     = S_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  // Storage has no reset; the sweep zeroes one word per cycle while not ready.
  always_ff @(posedge clk) begin
    if (!ready_o) begin
      for (int k = 0; k < 8; k++) begin
        mem[clear_idx_q + AW'(k)] <= 8'h00;
      end
    end else if (wr_en) begin
      for (int k = 0; k < 8; k++) begin
        mem[base + AW'(k)] <= data_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt_o   <= '0;
      store_cnt_o  <= '0;
      err_sticky_o <= 1'b0;
      err_addr_o   <= '0;
    end else begin
      if (ld_en) begin
        load_cnt_o <= load_cnt_o + CNT_W'(1);
      end
      if (wr_en) begin
        store_cnt_o <= store_cnt_o + CNT_W'(1);
      end
      if (err && !err_sticky_o) begin
        err_sticky_o <= 1'b1;
        err_addr_o   <= addr_i;
      end
    end
  end

endmodule

// File: tb/tb_y86_dmem.sv
// tb/tb_y86_dmem.sv - randomized self-checking bench for y86_dmem against a byte-array reference model
module tb_y86_dmem;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        write, read;
  logic [63:0] addr, data;
  logic [63:0] data_o, err_addr;
  logic        mem_error, ready, err_sticky;
  logic [31:0] load_cnt, store_cnt;

  logic        s_write, s_read;
  logic [63:0] s_addr, s_data;
  logic [63:0] s_data_o, s_err_addr;
  logic        s_mem_error, s_ready, s_err_sticky;
  logic [3:0]  s_load_cnt, s_store_cnt;

  always #5 clk = ~clk;

  y86_dmem #(.MEM_BYTES(MB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .write_i(write), .read_i(read), .addr_i(addr), .data_i(data),
    .data_o(data_o), .mem_error_o(mem_error), .ready_o(ready), .err_sticky_o(err_sticky),
    .err_addr_o(err_addr), .load_cnt_o(load_cnt), .store_cnt_o(store_cnt)
  );

  y86_dmem #(.MEM_BYTES(16), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .write_i(s_write), .read_i(s_read), .addr_i(s_addr), .data_i(s_data),
    .data_o(s_data_o), .mem_error_o(s_mem_error), .ready_o(s_ready), .err_sticky_o(s_err_sticky),
    .err_addr_o(s_err_addr), .load_cnt_o(s_load_cnt), .store_cnt_o(s_store_cnt)
  );

  logic [7:0]  ref_mem [MB];
  bit          ref_ready;
  int          ref_edges;
  logic [31:0] ref_lcnt, ref_scnt;
  bit          ref_sticky;
  logic [63:0] ref_eaddr;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] cap_data;
  logic        cap_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_word(input logic [63:0] a);
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[int'(a) + k];
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    ref_ready  = 0;
    ref_edges  = 0;
    ref_lcnt   = '0;
    ref_scnt   = '0;
    ref_sticky = 0;
    ref_eaddr  = '0;
  endtask

  task automatic do_reset();
    write = 0; read = 1; addr = 64'h0; data = '0;
    s_write = 0; s_read = 0; s_addr = '0; s_data = '0;
    rst = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_load_cnt", load_cnt, 0);
    chk("rst_store_cnt", store_cnt, 0);
    chk("rst_data", data_o, 0);
    chk("rst_mem_error", mem_error, 0);
    model_reset();
    read = 0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic do_access(input bit w, input bit r, input logic [63:0] a, input logic [63:0] d);
    bit bad;
    write = w; read = r; addr = a; data = d;
    bad = a > 64'(MB - 8);
    @(negedge clk);
    cap_data = data_o;
    cap_err  = mem_error;
    chk("mem_error", mem_error, ref_ready && (w || r) && bad);
    chk("data", data_o, (ref_ready && r && !bad) ? ref_word(a) : 64'd0);
    chk("ready", ready, ref_ready);
    chk("load_cnt", load_cnt, ref_lcnt);
    chk("store_cnt", store_cnt, ref_scnt);
    chk("sticky", err_sticky, ref_sticky);
    chk("err_addr", err_addr, ref_eaddr);
    @(posedge clk);
    if (!ref_ready) begin
      ref_edges++;
      if (ref_edges == MB / 8) ref_ready = 1;
    end else begin
      if (w && !bad) begin
        for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = d[8*k +: 8];
        ref_scnt++;
      end
      if (r && !w && !bad) ref_lcnt++;
      if ((w || r) && bad && !ref_sticky) begin
        ref_sticky = 1;
        ref_eaddr  = a;
      end
    end
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ref_ready && n < 200) begin
      do_access(0, 0, 64'h0, 64'h0);
      n++;
    end
    chk("sweep_bound", ref_ready, 1);
  endtask

  initial begin
    logic [63:0] a, d;
    int sel;
    bit w, r;

    rst = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) do_access(0, 0, 64'h0, 64'h0);
    do_reset();

    // Strobes during the sweep must have no effect.
    for (int i = 0; i < 9; i++) do_access(0, 0, 64'h0, 64'h0);
    do_access(1, 0, 64'h0, 64'hAA);
    chk("clear_store_err", cap_err, 0);
    wait_ready();
    do_access(0, 1, 64'h0, 64'h0);
    chk("clear_store_ignored", cap_data, 64'h0);

    // Fill memory with garbage, then reset and expect all zeros.
    for (int i = 0; i < MB / 8; i++) do_access(1, 0, 64'(i * 8), {$urandom, $urandom} | 64'h1);
    do_reset();
    wait_ready();
    do_access(0, 1, 64'h3F8, 64'h0);
    chk("sweep_zero_3f8", cap_data, 64'h0);
    for (int i = 0; i < 8; i++) do_access(0, 1, 64'($urandom_range(0, MB - 8)), 64'h0);

    do_reset();
    wait_ready();
    do_access(1, 0, 64'h100, 64'h0123456789ABCDEF);
    do_access(0, 1, 64'h100, 64'h0);
    chk("aligned_100", cap_data, 64'h0123456789ABCDEF);
    do_access(0, 1, 64'h101, 64'h0);
    chk("unaligned_101", cap_data, 64'h000123456789ABCD);
    do_access(0, 0, 64'h0, 64'h0);
    chk("aligned_store_cnt", store_cnt, 1);
    chk("aligned_load_cnt", load_cnt, 2);

    do_access(1, 0, 64'h3F8, 64'hDEADBEEFCAFEF00D);
    chk("boundary_store_err", cap_err, 0);
    do_access(0, 1, 64'h3F9, 64'h0);
    chk("boundary_read_err", cap_err, 1);
    chk("boundary_read_data", cap_data, 64'h0);
    do_access(0, 0, 64'h0, 64'h0);
    chk("boundary_err_addr", err_addr, 64'h3F9);
    chk("boundary_sticky", err_sticky, 1);
    do_access(0, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0);
    chk("wrap_addr_err", cap_err, 1);
    do_access(0, 1, 64'h3F8, 64'h0);
    chk("boundary_readback", cap_data, 64'hDEADBEEFCAFEF00D);
    chk("err_addr_kept", err_addr, 64'h3F9);

    do_access(1, 0, 64'h40, 64'h11);
    do_access(1, 1, 64'h40, 64'h22);
    chk("simul_old_data", cap_data, 64'h11);
    do_access(0, 1, 64'h40, 64'h0);
    chk("simul_new_data", cap_data, 64'h22);

    do_reset();
    wait_ready();
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 64'($urandom_range(0, MB - 8));
      else if (sel < 8)  a = 64'($urandom_range(MB - 12, MB + 4));
      else if (sel == 8) a = {$urandom, $urandom};
      else               a = 64'(MB - 8);
      d = {$urandom, $urandom};
      w = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 1) == 1;
      do_access(w, r, a, d);
    end

    // Narrow counter instance: 17 loads wrap a 4-bit count to 1.
    s_read = 1; s_addr = 64'h0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("small_cnt16", s_load_cnt, 0);
    @(posedge clk);
    #1;
    s_read = 0;
    @(negedge clk);
    chk("small_cnt_wrap", s_load_cnt, 1);
    s_read = 1; s_addr = 64'h9;
    #1;
    chk("small_bad_err", s_mem_error, 1);
    s_read = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
